edge_counter: RTL

//  Consumes the single-bit output of the inverter stage, which is asynchronous to clk.

---
 rtl/edge_counter_pkg.sv | 8 +
 rtl/sync_ff.sv | 16 +
 rtl/edge_counter.sv | 95 +++++++++
 3 files changed

// File: rtl/edge_counter_pkg.sv
// edge_counter_pkg: edge-select encodings and snapshot FSM states shared by the edge counter.
package edge_counter_pkg;
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_NONE = 2'b11;
  typedef enum logic {SNAP_IDLE = 1'b0, SNAP_HOLD = 1'b1} snap_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: async-reset multi-flop synchroniser for a single asynchronous input bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], d};
  end
  assign q = r_sync[STAGES-1];
endmodule

// File: rtl/edge_counter.sv
// edge_counter: synchronises an async bit, counts selected edges in a saturating counter
// and exposes the count through a four-phase snapshot handshake.
module edge_counter
  import edge_counter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic [1:0]       edge_sel,
  input  logic             clr,
  input  logic             snap_req,
  output logic             snap_ack,
  output logic [CNT_W-1:0] snap_val,
  output logic [CNT_W-1:0] count,
  output logic             edge_pulse,
  output logic             ovf
);
  localparam int ARM_N = SYNC_STAGES + 1;
  localparam int ARM_W = $clog2(ARM_N + 1);
  logic             w_s;
  logic             r_prev;
  logic [ARM_W-1:0] r_arm;
  logic             w_armed;
  logic             w_det;
  logic             w_hit;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_snap_val;
  logic             r_ovf;
  logic             r_pulse;
  snap_state_t      r_state;
  snap_state_t      w_state_nxt;
  logic             w_capture;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (w_s)
  );
  // Edges are ignored until the sync chain and prev hold real post-reset samples.
  assign w_armed = r_arm == ARM_W'(ARM_N);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_arm  <= '0;
    end else begin
      r_prev <= w_s;
      if (!w_armed) r_arm <= r_arm + ARM_W'(1);
    end
  end
  always_comb begin
    w_det = (edge_sel == EDGE_RISE) ? (w_s & ~r_prev) :
            (edge_sel == EDGE_FALL) ? (~w_s & r_prev) :
            (edge_sel == EDGE_BOTH) ? (w_s ^ r_prev) : 1'b0;
    w_hit = w_armed & en & w_det;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_hit;
      if (clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_hit) begin
        if (&r_count) r_ovf <= 1'b1;
        else r_count <= r_count + CNT_W'(1);
      end
    end
  end
  // HOLD persists exactly while the request is high, so next state follows snap_req.
  always_comb begin
    w_state_nxt = snap_req ? SNAP_HOLD : SNAP_IDLE;
    w_capture   = (r_state == SNAP_IDLE) && snap_req;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SNAP_IDLE;
      r_snap_val <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_snap_val <= r_count;
    end
  end
  assign snap_ack   = r_state == SNAP_HOLD;
  assign snap_val   = r_snap_val;
  assign count      = r_count;
  assign edge_pulse = r_pulse;
  assign ovf        = r_ovf;
endmodule
